router_sync_n: RTL and testbench

- Parametrised N-channel synchroniser between the router FSM, the register block and N output FIFOs.
- Latches the destination address from the header byte and holds it for the whole packet.
- Generates one-hot FIFO write enables and muxes the selected FIFO's full flag.
- Drives valid-out per channel and runs an independent, concurrent read-timeout timer per channel that pulses a soft reset to a stalled FIFO.

---
 rtl/router_pkg.sv | 16 +
 rtl/router_sync_timer.sv | 40 ++++
 rtl/router_sync_n.sv | 111 +++++++++++
 tb/tb_router_sync_n.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared constants and types for the router synchroniser slice.
package router_pkg;

   // Default build of the synchroniser: 3 output FIFOs, 2-bit header address.
   localparam int ROUTER_NUM_CH  = 3;
   localparam int ROUTER_ADDR_W  = 2;
   localparam int ROUTER_TIMEOUT = 30;
   localparam int ROUTER_TIMER_W = 5;

   // Address latch FSM: IDLE waits for a header, HOLD keeps the channel for the packet.
   typedef enum logic {
      ADDR_IDLE = 1'b0,
      ADDR_HOLD = 1'b1
   } addr_state_t;

endpackage : router_pkg

// File: rtl/router_sync_timer.sv
// Per-channel read-timeout timer: counts consecutive valid-but-unread cycles
// and pulses soft_reset for one cycle when the reader has stalled too long.
module router_sync_timer
   import router_pkg::*;
#(
   parameter int TIMEOUT = ROUTER_TIMEOUT,
   parameter int TIMER_W = ROUTER_TIMER_W
) (
   input  logic clock,
   input  logic resetn,
   input  logic vld,
   input  logic rd,
   output logic soft_reset
);

   // Terminal count; the pulse fires on the edge that ends the TIMEOUT-th stalled cycle.
   localparam logic [TIMER_W-1:0] TERM = TIMER_W'(TIMEOUT - 1);

   logic [TIMER_W-1:0] timer;

   // Count stalled cycles; a read or an empty FIFO clears the count, terminal count pulses.
   // NOTE: reset is synchronous (sampled on the clock edge), so it sits inside the clocked branch.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         timer      <= '0;
         soft_reset <= 1'b0;
      end else if (!vld || rd) begin
         timer      <= '0;
         soft_reset <= 1'b0;
      end else if (timer == TERM) begin
         timer      <= '0;
         soft_reset <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments for all state, so every register updates from pre-edge values.
         timer      <= timer + 1'b1;
         soft_reset <= 1'b0;
      end
   end

endmodule : router_sync_timer

// File: rtl/router_sync_n.sv
// N-channel synchroniser between router FSM, register block and output FIFOs:
// latches the packet's destination, decodes FIFO write enables, muxes the
// selected full flag, drives valid-out and runs one read-timeout per channel.
module router_sync_n
   import router_pkg::*;
#(
   parameter int NUM_CH  = ROUTER_NUM_CH,
   parameter int ADDR_W  = ROUTER_ADDR_W,
   parameter int TIMEOUT = ROUTER_TIMEOUT,
   parameter int TIMER_W = ROUTER_TIMER_W
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              detect_add,
   input  logic [ADDR_W-1:0] data_in,
   input  logic              pkt_done,
   input  logic              write_enb_reg,
   input  logic [NUM_CH-1:0] read_enb,
   input  logic [NUM_CH-1:0] empty,
   input  logic [NUM_CH-1:0] full,
   output logic [NUM_CH-1:0] write_enb,
   output logic              fifo_full,
   output logic [NUM_CH-1:0] vld_out,
   output logic [NUM_CH-1:0] soft_reset,
   output logic              addr_valid,
   output logic              err_bad_addr
);

   // Channel count widened by one bit so the range check also works when 2**ADDR_W == NUM_CH.
   localparam logic [ADDR_W:0] NUM_CH_EXT = (ADDR_W + 1)'(NUM_CH);

   addr_state_t       state;
   logic [ADDR_W-1:0] addr_reg;
   logic              hdr_ok;
   logic              sel_soft_reset;
   logic              sel_full;

   assign hdr_ok  = ({1'b0, data_in} < NUM_CH_EXT);
   assign vld_out = ~empty;

   // Select the latched channel's full flag and soft reset; decode the one-hot write enable.
   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      sel_soft_reset = 1'b0;
      sel_full       = 1'b0;
      write_enb      = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (addr_reg == ADDR_W'(i)) begin
            sel_soft_reset = soft_reset[i];
            sel_full       = full[i];
            write_enb[i]   = write_enb_reg & addr_valid;
         end
      end
   end

   assign fifo_full = addr_valid & sel_full;

   // Address FSM: latch a valid header, hold it until packet end, flush or a new header.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state        <= ADDR_IDLE;
         addr_reg     <= '0;
         addr_valid   <= 1'b0;
         err_bad_addr <= 1'b0;
      end else begin
         err_bad_addr <= detect_add & ~hdr_ok;
         case (state)
            ADDR_IDLE: begin
               if (detect_add && hdr_ok) begin
                  addr_reg   <= data_in;
                  addr_valid <= 1'b1;
                  state      <= ADDR_HOLD;
               end
            end
            ADDR_HOLD: begin
               // A new header takes priority over packet end and over a flush of the old channel.
               if (detect_add) begin
                  if (hdr_ok) begin
                     addr_reg <= data_in;
                  end else begin
                     addr_valid <= 1'b0;
                     state      <= ADDR_IDLE;
                  end
               end else if (pkt_done || sel_soft_reset) begin
                  addr_valid <= 1'b0;
                  state      <= ADDR_IDLE;
               end
            end
            default: begin
               addr_valid <= 1'b0;
               state      <= ADDR_IDLE;
            end
         endcase
      end
   end

   // One independent read-timeout timer per output channel.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_timer
      router_sync_timer #(
         .TIMEOUT (TIMEOUT),
         .TIMER_W (TIMER_W)
      ) u_timer (
         .clock      (clock),
         .resetn     (resetn),
         .vld        (vld_out[g]),
         .rd         (read_enb[g]),
         .soft_reset (soft_reset[g])
      );
   end

endmodule : router_sync_n

// File: tb/tb_router_sync_n.sv
// Bench for router_sync_n: a table of short address-FSM vectors with hand
// expectations, then hand-written timer sequences; every cycle is also
// compared against a reference model through a scoreboard queue.
module tb_router_sync_n;
   import router_pkg::*;

   localparam int NUM_CH  = ROUTER_NUM_CH;
   localparam int ADDR_W  = ROUTER_ADDR_W;
   localparam int TIMEOUT = ROUTER_TIMEOUT;
   localparam int TIMER_W = ROUTER_TIMER_W;

   logic              clock = 1'b0;
   logic              resetn;
   logic              detect_add;
   logic [ADDR_W-1:0] data_in;
   logic              pkt_done;
   logic              write_enb_reg;
   logic [NUM_CH-1:0] read_enb;
   logic [NUM_CH-1:0] empty;
   logic [NUM_CH-1:0] full;
   logic [NUM_CH-1:0] write_enb;
   logic              fifo_full;
   logic [NUM_CH-1:0] vld_out;
   logic [NUM_CH-1:0] soft_reset;
   logic              addr_valid;
   logic              err_bad_addr;

   always #5 clock = ~clock;

   router_sync_n #(
      .NUM_CH  (NUM_CH),
      .ADDR_W  (ADDR_W),
      .TIMEOUT (TIMEOUT),
      .TIMER_W (TIMER_W)
   ) dut (
      .clock         (clock),
      .resetn        (resetn),
      .detect_add    (detect_add),
      .data_in       (data_in),
      .pkt_done      (pkt_done),
      .write_enb_reg (write_enb_reg),
      .read_enb      (read_enb),
      .empty         (empty),
      .full          (full),
      .write_enb     (write_enb),
      .fifo_full     (fifo_full),
      .vld_out       (vld_out),
      .soft_reset    (soft_reset),
      .addr_valid    (addr_valid),
      .err_bad_addr  (err_bad_addr)
   );

   typedef struct packed {
      logic              resetn;
      logic              detect_add;
      logic [ADDR_W-1:0] data_in;
      logic              pkt_done;
      logic              wer;
      logic [NUM_CH-1:0] read_enb;
      logic [NUM_CH-1:0] empty;
      logic [NUM_CH-1:0] full;
   } in_t;

   typedef struct packed {
      logic [NUM_CH-1:0] we;
      logic              ff;
      logic [NUM_CH-1:0] vld;
      logic [NUM_CH-1:0] sr;
      logic              av;
      logic              err;
   } out_t;

   typedef struct {
      in_t               in;
      logic [NUM_CH-1:0] we;
      logic              av;
      logic              err;
      logic              ff;
   } vec_t;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   out_t sb[$];
   out_t obs;

   // Reference model state
   bit                m_av;
   int                m_addr;
   bit                m_err;
   int                m_run[NUM_CH];
   bit [NUM_CH-1:0]   m_sr;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic in_t mk(input logic det, input logic [ADDR_W-1:0] d, input logic pd,
                              input logic wer, input logic [NUM_CH-1:0] fl);
      in_t v;
      v.resetn     = 1'b1;
      v.detect_add = det;
      v.data_in    = d;
      v.pkt_done   = pd;
      v.wer        = wer;
      v.read_enb   = '0;
      v.empty      = '1;
      v.full       = fl;
      return v;
   endfunction

   function automatic in_t mk_ch(input logic [NUM_CH-1:0] emp, input logic [NUM_CH-1:0] rd);
      in_t v;
      v          = mk(1'b0, '0, 1'b0, 1'b0, '0);
      v.empty    = emp;
      v.read_enb = rd;
      return v;
   endfunction

   function automatic out_t model_out(input in_t v);
      out_t e;
      e.we  = '0;
      if (v.wer && m_av) e.we[m_addr] = 1'b1;
      e.ff  = m_av ? v.full[m_addr] : 1'b0;
      e.vld = ~v.empty;
      e.sr  = m_sr;
      e.av  = m_av;
      e.err = m_err;
      return e;
   endfunction

   task automatic model_step(input in_t v);
      bit hdr_ok;
      if (!v.resetn) begin
         m_av = 0; m_addr = 0; m_err = 0; m_sr = '0;
         for (int i = 0; i < NUM_CH; i++) m_run[i] = 0;
      end else begin
         hdr_ok = int'(v.data_in) < NUM_CH;
         m_err  = v.detect_add && !hdr_ok;
         // The FSM sees the flush pulse as it was before this edge.
         if (v.detect_add) begin
            if (hdr_ok) begin
               m_av   = 1;
               m_addr = int'(v.data_in);
            end else begin
               m_av = 0;
            end
         end else if (m_av && (v.pkt_done || m_sr[m_addr])) begin
            m_av = 0;
         end
         for (int i = 0; i < NUM_CH; i++) begin
            if (v.empty[i] || v.read_enb[i]) begin
               m_run[i] = 0;
               m_sr[i]  = 0;
            end else begin
               m_run[i]++;
               if (m_run[i] == TIMEOUT) begin
                  m_sr[i]  = 1;
                  m_run[i] = 0;
               end else begin
                  m_sr[i] = 0;
               end
            end
         end
      end
   endtask

   // One clock cycle: drive, push expectation, sample mid-cycle, compare, then take the edge.
   task automatic drive(input in_t v);
      out_t e;
      resetn        = v.resetn;
      detect_add    = v.detect_add;
      data_in       = v.data_in;
      pkt_done      = v.pkt_done;
      write_enb_reg = v.wer;
      read_enb      = v.read_enb;
      empty         = v.empty;
      full          = v.full;
      sb.push_back(model_out(v));
      #2;
      obs = '{we: write_enb, ff: fifo_full, vld: vld_out, sr: soft_reset,
              av: addr_valid, err: err_bad_addr};
      e = sb.pop_front();
      check("sb_write_enb",    8'(obs.we),  8'(e.we));
      check("sb_fifo_full",    8'(obs.ff),  8'(e.ff));
      check("sb_vld_out",      8'(obs.vld), 8'(e.vld));
      check("sb_soft_reset",   8'(obs.sr),  8'(e.sr));
      check("sb_addr_valid",   8'(obs.av),  8'(e.av));
      check("sb_err_bad_addr", 8'(obs.err), 8'(e.err));
      @(posedge clock);
      model_step(v);
      cyc++;
      #1;
   endtask

   function automatic vec_t vec(input in_t v, input logic [NUM_CH-1:0] we, input logic av,
                                input logic err, input logic ff);
      vec_t t;
      t.in = v; t.we = we; t.av = av; t.err = err; t.ff = ff;
      return t;
   endfunction

   initial begin
      vec_t tbl[$];
      int   first0, first1, first2;
      int   seen1;
      in_t  v;

      // Hold reset across two edges; outputs before the first edge are unknown.
      v        = mk(1'b0, '0, 1'b0, 1'b0, '0);
      v.resetn = 1'b0;
      resetn = 0; detect_add = 0; data_in = '0; pkt_done = 0; write_enb_reg = 0;
      read_enb = '0; empty = '1; full = '0;
      repeat (2) @(posedge clock);
      model_step(v);
      #1;

      //              det  data   pd   wer  full        we      av   err  ff
      tbl.push_back(vec(mk(0, 2'd0, 0, 1, 3'b000), 3'b000, 0, 0, 0)); // reset state
      tbl.push_back(vec(mk(1, 2'd1, 0, 1, 3'b000), 3'b000, 0, 0, 0)); // header, not yet latched
      tbl.push_back(vec(mk(0, 2'd0, 0, 1, 3'b000), 3'b010, 1, 0, 0)); // latched ch1
      tbl.push_back(vec(mk(0, 2'd0, 0, 0, 3'b000), 3'b000, 1, 0, 0));
      tbl.push_back(vec(mk(0, 2'd0, 1, 1, 3'b010), 3'b010, 1, 0, 1)); // last byte
      tbl.push_back(vec(mk(0, 2'd0, 0, 1, 3'b010), 3'b000, 0, 0, 0)); // released
      tbl.push_back(vec(mk(1, 2'd3, 0, 1, 3'b000), 3'b000, 0, 0, 0)); // bad header
      tbl.push_back(vec(mk(0, 2'd0, 0, 1, 3'b000), 3'b000, 0, 1, 0)); // error pulse
      tbl.push_back(vec(mk(0, 2'd0, 0, 1, 3'b000), 3'b000, 0, 0, 0)); // pulse is one cycle
      tbl.push_back(vec(mk(1, 2'd2, 0, 0, 3'b000), 3'b000, 0, 0, 0));
      tbl.push_back(vec(mk(0, 2'd0, 0, 1, 3'b100), 3'b100, 1, 0, 1)); // ch2, full muxed
      tbl.push_back(vec(mk(1, 2'd0, 1, 1, 3'b100), 3'b100, 1, 0, 1)); // pkt_done + new header
      tbl.push_back(vec(mk(0, 2'd0, 0, 1, 3'b100), 3'b001, 1, 0, 0)); // re-latched ch0
      tbl.push_back(vec(mk(1, 2'd3, 0, 0, 3'b000), 3'b000, 1, 0, 0)); // bad header in HOLD
      tbl.push_back(vec(mk(0, 2'd0, 0, 1, 3'b000), 3'b000, 0, 1, 0));
      tbl.push_back(vec(mk(1, 2'd1, 0, 0, 3'b000), 3'b000, 0, 0, 0));
      tbl.push_back(vec(mk(1, 2'd2, 0, 1, 3'b000), 3'b010, 1, 0, 0)); // back-to-back header
      tbl.push_back(vec(mk(0, 2'd0, 0, 1, 3'b000), 3'b100, 1, 0, 0));
      tbl.push_back(vec(mk(0, 2'd0, 1, 0, 3'b000), 3'b000, 1, 0, 0));
      tbl.push_back(vec(mk(0, 2'd0, 0, 1, 3'b000), 3'b000, 0, 0, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].in);
         check($sformatf("tbl%0d_write_enb", i),    8'(obs.we),  8'(tbl[i].we));
         check($sformatf("tbl%0d_addr_valid", i),   8'(obs.av),  8'(tbl[i].av));
         check($sformatf("tbl%0d_err_bad_addr", i), 8'(obs.err), 8'(tbl[i].err));
         check($sformatf("tbl%0d_fifo_full", i),    8'(obs.ff),  8'(tbl[i].ff));
      end

      // Stalled ch0 while HOLD on ch0: pulse in cycle 30, FSM drops the packet.
      drive(mk(1, 2'd0, 0, 0, 3'b000));
      first0 = -1;
      for (int j = 0; j < 33; j++) begin
         drive(mk_ch(3'b110, 3'b000));
         if (obs.sr[0] && first0 < 0) first0 = j;
         if (j == 30) check("stall0_av_at_pulse", 8'(obs.av), 8'd1);
         if (j == 31) check("stall0_av_after_pulse", 8'(obs.av), 8'd0);
      end
      check("stall0_first_pulse", 8'(first0), 8'd30);
      repeat (2) drive(mk_ch(3'b111, 3'b000));

      // ch0 and ch2 stall together; ch1 idle.
      first0 = -1; first2 = -1; seen1 = 0;
      for (int j = 0; j < 33; j++) begin
         drive(mk_ch(3'b010, 3'b000));
         if (obs.sr[0] && first0 < 0) first0 = j;
         if (obs.sr[2] && first2 < 0) first2 = j;
         if (obs.sr[1]) seen1 = 1;
      end
      check("dual_first_pulse_ch0", 8'(first0), 8'd30);
      check("dual_first_pulse_ch2", 8'(first2), 8'd30);
      check("dual_ch1_quiet", 8'(seen1), 8'd0);
      repeat (2) drive(mk_ch(3'b111, 3'b000));

      // ch1 read at terminal count: no pulse, next pulse 30 cycles later.
      first1 = -1;
      for (int j = 0; j < 62; j++) begin
         drive(mk_ch(3'b101, (j == 29) ? 3'b010 : 3'b000));
         if (obs.sr[1] && first1 < 0) first1 = j;
      end
      check("read_at_term_first_pulse", 8'(first1), 8'd60);
      repeat (2) drive(mk_ch(3'b111, 3'b000));

      // Reset mid-packet and mid-count: everything restarts from zero.
      drive(mk(1, 2'd2, 0, 0, 3'b000));
      for (int j = 0; j < 10; j++) drive(mk_ch(3'b000, 3'b000));
      v        = mk_ch(3'b000, 3'b000);
      v.resetn = 1'b0;
      drive(v);
      first0 = -1;
      for (int j = 0; j < 33; j++) begin
         drive(mk_ch(3'b000, 3'b000));
         if (j == 0) begin
            check("rst_mid_addr_valid", 8'(obs.av), 8'd0);
            check("rst_mid_soft_reset", 8'(obs.sr), 8'd0);
         end
         if (obs.sr[0] && first0 < 0) first0 = j;
      end
      check("rst_mid_first_pulse", 8'(first0), 8'd30);
      repeat (2) drive(mk_ch(3'b111, 3'b000));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_router_sync_n
